nyan_sprite_sequencer: RTL
==========================

// Module: nyan_sprite_sequencer
// PURPOSE
//  Scans a scaled, animated 4-bit-indexed sprite into the VGA pixel stream.
//  Takes the raster column/row from the sync generator and computes the sprite ROM address.
//  Sends the returned index to the 16-entry 9-bit palette LUT and registers the RGB333 result.
//  Sequences animation frames on vertical-blank ticks. Sits between the sync counters, the sprite ROM and the palette.
// PARAMETERS
//  SPR_W       32      sprite width in source pixels (power of 2)
//  SPR_H       20      sprite height in source pixels
//  SCALE_LOG2  2       on-screen magnification = 2**SCALE_LOG2 in both axes
//  NUM_FRAMES  6       animation frames stored back-to-back in ROM
//  FRAME_HOLD  4       frame_start pulses per animation step (>=1)
//  COL_W/ROW_W 10/10   raster counter widths
//  BG_COLOR    9'h000  color outside the sprite window
// PORTS
//  i_clk          in   1      pixel clock
//  i_rst_n        in   1      synchronous reset, active-low
//  i_col          in   COL_W  raster column
//  i_row          in   ROW_W  raster row
//  i_active       in   1      visible-area flag, aligned with i_col/i_row
//  i_frame_start  in   1      one-cycle pulse at start of vertical blank
//  i_pause        in   1      freeze animation
//  i_pos_x        in   COL_W  sprite top-left x (screen px); sampled at frame_start
//  i_pos_y        in   ROW_W  sprite top-left y; sampled at frame_start
//  o_rom_addr     out  AW     AW=clog2(NUM_FRAMES*SPR_W*SPR_H)
//  i_rom_index    in   4      ROM data, valid exactly 1 cycle after o_rom_addr
//  o_pal_index    out  4      to palette LUT (combinational lookup)
//  i_pal_color    in   9      palette result for o_pal_index
//  o_color        out  9      registered RGB333 pixel
//  o_active       out  1      i_active delayed by 3 cycles (pipeline-aligned)
//  o_anim_frame   out  clog2(NUM_FRAMES)  current animation frame
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): o_color=0, o_active=0, o_rom_addr=0, o_anim_frame=0.
//   Hold counter=0, latched position=0, all pipeline valid/in-window flags cleared.
//   A reset mid-line/mid-frame discards in-flight pixels; no stale color leaves after reset.
//  Pipeline, fixed latency 3 (i_col/i_row at cycle N -> o_color at N+3):
//   S1: dx=i_col-pos_x, dy=i_row-pos_y in COL_W+1/ROW_W+1 bits, signed, no wrap.
//    in_win = dx>=0 && dx<SPR_W<<SCALE_LOG2 && dy>=0 && dy<SPR_H<<SCALE_LOG2 && i_active.
//    Register o_rom_addr = anim*SPR_W*SPR_H + (dy>>S)*SPR_W + (dx>>S).
//    Outside the window the address holds its last value.
//   S2: ROM returns index; register index and in_win.
//   S3: o_pal_index=index_q. o_color <= !active_q2 ? 0 : in_win_q2 ? i_pal_color : BG_COLOR.
//  Windows extending past the raster edge are clipped by the compares; no wrap to col 0.
//  Position is latched only on i_frame_start, giving a tear-free move per frame.
//  Animation FSM (states RUN, PAUSED), evaluated only on cycles with i_frame_start=1:
//   RUN: hold_cnt++ ; when hold_cnt==FRAME_HOLD-1, set hold_cnt=0 and advance anim.
//    Anim wraps NUM_FRAMES-1 -> 0.
//   RUN -> PAUSED when i_pause=1 (pause wins over a same-cycle step).
//   PAUSED -> RUN when i_pause=0; hold_cnt is preserved.
//   o_anim_frame changes only on frame_start, never mid-frame.
// CONFIGURATION
//  NYAN_TRANSPARENCY_EN defined:
//   index 0 treated as transparent; S3 outputs BG_COLOR when in_win && index==0.
//  Undefined: index 0 is passed through the palette like any other index.
// STRUCTURE
//  Package nyan_pkg: RGB_W=9, IDX_W=4, typedef rgb333_t and index_t, BG black constant.
//  Sub-module nyan_anim_counter: RUN/PAUSED FSM, hold counter, frame wrap.
//   Outputs the anim index.
//  Top keeps the window compare, address arithmetic and 3-stage pipeline.
// TESTING
//  pos=(100,50), anim=0, col=100,row=50 -> o_rom_addr=0 at N+1; o_color=palette(idx) at N+3.
//  col=227,row=50 (S=2) -> addr=31; col=228 -> out of window, o_color=BG_COLOR, addr held.
//  FRAME_HOLD=4, 24 frame_start pulses -> anim 0..5 each for 4 pulses, then back to 0.
//  i_pause=1 across 10 pulses -> anim frozen; release -> resumes with preserved hold_cnt.
//  pos_x=1000, col 1000..1023 -> in window; no hit at col 0..7 on the next line (no wrap).
//  Reset at mid-window pixel -> o_color=0, o_active=0 for 3 cycles, anim=0.
//  NYAN_TRANSPARENCY_EN with ROM idx 0 -> BG_COLOR; without -> palette(0).

Source files
------------

// File: rtl/nyan_pkg.sv
// Shared types and constants for the nyan sprite sequencer.
package nyan_pkg;

    localparam int unsigned RGB_W = 9;
    localparam int unsigned IDX_W = 4;

    typedef logic [RGB_W-1:0] rgb333_t;
    typedef logic [IDX_W-1:0] index_t;

    localparam rgb333_t BG_BLACK = '0;

    typedef enum logic {
        ANIM_RUN    = 1'b0,
        ANIM_PAUSED = 1'b1
    } anim_state_e;

    // Bit width needed to hold 0..n-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nyan_sprite_sequencer_if.sv
// Raster, sprite-ROM and palette connections of the sprite sequencer.
// master: raster/ROM/palette side; slave: the sequencer.
interface nyan_sprite_sequencer_if #(
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 10,
    parameter int unsigned AW    = 12,
    parameter int unsigned FW    = 3
);
    import nyan_pkg::*;

    logic [COL_W-1:0] i_col;
    logic [ROW_W-1:0] i_row;
    logic             i_active;
    logic             i_frame_start;
    logic             i_pause;
    logic [COL_W-1:0] i_pos_x;
    logic [ROW_W-1:0] i_pos_y;
    logic [AW-1:0]    o_rom_addr;
    index_t           i_rom_index;
    index_t           o_pal_index;
    rgb333_t          i_pal_color;
    rgb333_t          o_color;
    logic             o_active;
    logic [FW-1:0]    o_anim_frame;

    modport master (
        output i_col, i_row, i_active, i_frame_start, i_pause, i_pos_x, i_pos_y,
        output i_rom_index, i_pal_color,
        input  o_rom_addr, o_pal_index, o_color, o_active, o_anim_frame
    );

    modport slave (
        input  i_col, i_row, i_active, i_frame_start, i_pause, i_pos_x, i_pos_y,
        input  i_rom_index, i_pal_color,
        output o_rom_addr, o_pal_index, o_color, o_active, o_anim_frame
    );

endinterface

// File: rtl/nyan_anim_counter.sv
// Animation frame sequencer: RUN/PAUSED FSM stepping on vertical-blank ticks.
module nyan_anim_counter
    import nyan_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = 6,
    parameter int unsigned FRAME_HOLD = 4,
    parameter int unsigned FW         = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_frame_start,
    input  logic          i_pause,
    output logic [FW-1:0] o_anim_frame
);

    localparam int unsigned HW = width_of(FRAME_HOLD);

    anim_state_e   state_q;
    logic [HW-1:0] hold_q;
    logic [FW-1:0] frame_q;

    // Pause and stepping are only looked at on frame_start, so the frame never changes mid-picture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ANIM_RUN;
            hold_q  <= '0;
            frame_q <= '0;
        end else if (i_frame_start) begin
            case (state_q)
                ANIM_RUN: begin
                    if (i_pause) begin
                        state_q <= ANIM_PAUSED;
                    end else if (hold_q == HW'(FRAME_HOLD - 1)) begin
                        hold_q  <= '0;
                        frame_q <= (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                ANIM_PAUSED: begin
                    if (!i_pause) begin
                        state_q <= ANIM_RUN;
                    end
                end
                default: state_q <= ANIM_RUN;
            endcase
        end
    end

    assign o_anim_frame = frame_q;

endmodule

// File: rtl/nyan_sprite_sequencer.sv
// Scaled, animated 4-bit indexed sprite scan-out into an RGB333 pixel stream.
// Three-stage pipeline: window/address, ROM index, palette color.
// Optional build macro NYAN_TRANSPARENCY_EN: palette index 0 shows the background.
module nyan_sprite_sequencer
    import nyan_pkg::*;
#(
    parameter int unsigned SPR_W      = 32,
    parameter int unsigned SPR_H      = 20,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned NUM_FRAMES = 6,
    parameter int unsigned FRAME_HOLD = 4,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned ROW_W      = 10,
    parameter rgb333_t     BG_COLOR   = BG_BLACK
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    nyan_sprite_sequencer_if.slave bus
);

    localparam int unsigned FRAME_PIX = SPR_W * SPR_H;
    localparam int unsigned AW        = width_of(NUM_FRAMES * FRAME_PIX);
    localparam int unsigned FW        = width_of(NUM_FRAMES);
    localparam int unsigned WIN_W     = SPR_W << SCALE_LOG2;
    localparam int unsigned WIN_H     = SPR_H << SCALE_LOG2;

    logic [COL_W-1:0] pos_x_q;
    logic [ROW_W-1:0] pos_y_q;
    logic [AW-1:0]    rom_addr_q;
    logic             in_win_q1;
    logic             in_win_q2;
    logic             active_q1;
    logic             active_q2;
    logic             active_q3;
    index_t           index_q;
    rgb333_t          color_q;
    rgb333_t          color_d;

    logic [COL_W:0]   dx_c;
    logic [ROW_W:0]   dy_c;
    logic             in_win_c;
    logic [AW-1:0]    addr_c;
    logic [FW-1:0]    anim;

    // Frame sequencer.
    nyan_anim_counter #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FW         (FW)
    ) u_anim (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (bus.i_frame_start),
        .i_pause       (bus.i_pause),
        .o_anim_frame  (anim)
    );

    // Offsets carry an extra sign bit so a window hanging off the right/bottom edge never wraps.
    assign dx_c = {1'b0, bus.i_col} - {1'b0, pos_x_q};
    assign dy_c = {1'b0, bus.i_row} - {1'b0, pos_y_q};

    assign in_win_c = bus.i_active
                   && !dx_c[COL_W] && (dx_c[COL_W-1:0] < COL_W'(WIN_W))
                   && !dy_c[ROW_W] && (dy_c[ROW_W-1:0] < ROW_W'(WIN_H));

    assign addr_c = AW'(anim) * AW'(FRAME_PIX)
                  + AW'(dy_c[ROW_W-1:0] >> SCALE_LOG2) * AW'(SPR_W)
                  + AW'(dx_c[COL_W-1:0] >> SCALE_LOG2);

    // Final pixel select: blank outside active video, background outside the sprite.
    always_comb begin
        color_d = '0;
        if (active_q2) begin
            if (!in_win_q2) begin
                color_d = BG_COLOR;
            end
`ifdef NYAN_TRANSPARENCY_EN
            else if (index_q == '0) begin
                color_d = BG_COLOR;
            end
`endif
            else begin
                color_d = bus.i_pal_color;
            end
        end
    end

    // Position latch and the three pipeline stages; ROM data is consumed the cycle after its address.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            rom_addr_q <= '0;
            in_win_q1  <= 1'b0;
            in_win_q2  <= 1'b0;
            active_q1  <= 1'b0;
            active_q2  <= 1'b0;
            active_q3  <= 1'b0;
            index_q    <= '0;
            color_q    <= '0;
        end else begin
            if (bus.i_frame_start) begin
                pos_x_q <= bus.i_pos_x;
                pos_y_q <= bus.i_pos_y;
            end
            if (in_win_c) begin
                rom_addr_q <= addr_c;
            end
            in_win_q1 <= in_win_c;
            active_q1 <= bus.i_active;
            index_q   <= bus.i_rom_index;
            in_win_q2 <= in_win_q1;
            active_q2 <= active_q1;
            active_q3 <= active_q2;
            color_q   <= color_d;
        end
    end

    assign bus.o_rom_addr   = rom_addr_q;
    assign bus.o_pal_index  = index_q;
    assign bus.o_color      = color_q;
    assign bus.o_active     = active_q3;
    assign bus.o_anim_frame = anim;

endmodule
